// File: rtl/concat_splitter_pkg.sv
// Shared widths, FIFO occupancy type and occupancy-state constants for the concat slice splitter.
package concat_splitter_pkg;

  localparam int unsigned HI_W_DEF   = 3;
  localparam int unsigned LO_W_DEF   = 2;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t FIFO_EMPTY = 2'd0;
  localparam fifo_cnt_t FIFO_ONE   = 2'd1;
  localparam fifo_cnt_t FIFO_FULL  = 2'd2;

endpackage

// File: rtl/slice_fifo2.sv
// Two-entry register FIFO; dout shows the head and holds the last popped value while empty.
module slice_fifo2
  import concat_splitter_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output fifo_cnt_t    count
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  fifo_cnt_t    cnt_q, cnt_d;
  logic [W-1:0] dout_q, dout_d;
  logic         push_eff, pop_eff;

  // Pops on empty are dropped; a push on full only lands alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pop_eff  = pop && (cnt_q != FIFO_EMPTY);
    push_eff = push && ((cnt_q != FIFO_FULL) || pop_eff);
    if (push_eff) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_eff) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    dout_d = (cnt_d == FIFO_EMPTY) ? dout_q : mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= FIFO_EMPTY;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign count = cnt_q;

endmodule

// File: rtl/concat_slice_splitter.sv
// Splits a packed {hi, lo} word into two independently drained 2-entry FIFO streams.
// Optional CONCAT_SPLITTER_PARITY_EN adds an even-parity MSB on in_data and a par_err pulse.
module concat_slice_splitter
  import concat_splitter_pkg::*;
#(
  parameter int unsigned HI_W  = HI_W_DEF,
  parameter int unsigned LO_W  = LO_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef CONCAT_SPLITTER_PARITY_EN
  input  logic [HI_W+LO_W:0]   in_data,
`else
  input  logic [HI_W+LO_W-1:0] in_data,
`endif
  output logic                 hi_valid,
  input  logic                 hi_ready,
  output logic [HI_W-1:0]      hi_data,
  output logic                 lo_valid,
  input  logic                 lo_ready,
  output logic [LO_W-1:0]      lo_data,
`ifdef CONCAT_SPLITTER_PARITY_EN
  output logic                 par_err,
`endif
  output logic [CNT_W-1:0]     word_cnt
);

  fifo_cnt_t        hi_count, lo_count;
  logic             hi_pop, lo_pop;
  logic             accept;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  assign hi_valid = (hi_count != FIFO_EMPTY);
  assign lo_valid = (lo_count != FIFO_EMPTY);
  assign hi_pop   = hi_valid && hi_ready;
  assign lo_pop   = lo_valid && lo_ready;

  // Fork: a word enters both FIFOs or neither; a same-cycle pop frees a full slot.
  assign in_ready = ((hi_count != FIFO_FULL) || hi_pop) &&
                    ((lo_count != FIFO_FULL) || lo_pop);
  assign accept   = in_valid && in_ready;

  slice_fifo2 #(.W(HI_W)) u_hi_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (hi_pop),
    .din   (in_data[HI_W+LO_W-1:LO_W]),
    .dout  (hi_data),
    .count (hi_count)
  );

  slice_fifo2 #(.W(LO_W)) u_lo_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (lo_pop),
    .din   (in_data[LO_W-1:0]),
    .dout  (lo_data),
    .count (lo_count)
  );

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (accept) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

`ifdef CONCAT_SPLITTER_PARITY_EN
  logic par_err_q, par_err_d;

  // Even parity over payload plus parity bit must XOR to zero.
  always_comb begin
    par_err_d = accept && (^in_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_concat_slice_splitter.sv
// Directed self-checking bench for concat_slice_splitter (parity section under CONCAT_SPLITTER_PARITY_EN).
module tb_concat_slice_splitter;

`ifdef CONCAT_SPLITTER_PARITY_EN
  localparam int unsigned DW = 6;
`else
  localparam int unsigned DW = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          hi_valid, hi_ready;
  logic [2:0]    hi_data;
  logic          lo_valid, lo_ready;
  logic [1:0]    lo_data;
  logic [7:0]    word_cnt;
`ifdef CONCAT_SPLITTER_PARITY_EN
  logic          par_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_cnt;
  logic [4:0] w;

  always #5 clk = ~clk;

  concat_slice_splitter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .hi_valid (hi_valid),
    .hi_ready (hi_ready),
    .hi_data  (hi_data),
    .lo_valid (lo_valid),
    .lo_ready (lo_ready),
    .lo_data  (lo_data),
`ifdef CONCAT_SPLITTER_PARITY_EN
    .par_err  (par_err),
`endif
    .word_cnt (word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    hi_ready = 1'b0;
    lo_ready = 1'b0;
    #12;
    chk("rst_hi_valid", 32'(hi_valid), 0);
    chk("rst_lo_valid", 32'(lo_valid), 0);
    chk("rst_hi_data", 32'(hi_data), 0);
    chk("rst_lo_data", 32'(lo_data), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Single word split with 1-cycle latency
    in_valid = 1'b1; in_data = DW'(5'b10110); hi_ready = 1'b1; lo_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_hi_data", 32'(hi_data), 3'b101);
    chk("t1_lo_data", 32'(lo_data), 2'b10);
    chk("t1_hi_valid", 32'(hi_valid), 1);
    chk("t1_lo_valid", 32'(lo_valid), 1);
    chk("t1_word_cnt", 32'(word_cnt), 1);
    step();
    chk("t1_hi_drained", 32'(hi_valid), 0);
    chk("t1_hi_hold_last", 32'(hi_data), 3'b101);

    // hi stalled, lo draining: backpressure after two accepts
    hi_ready = 1'b0; lo_ready = 1'b1;
    in_valid = 1'b1; in_data = DW'(5'h01);
    step();
    chk("t2_ready_after1", 32'(in_ready), 1);
    chk("t2_lo_first", 32'(lo_data), 2'b01);
    in_data = DW'(5'h02);
    step();
    chk("t2_ready_drop", 32'(in_ready), 0);
    chk("t2_lo_second", 32'(lo_data), 2'b10);
    in_data = DW'(5'h03);
    step();
    chk("t2_word_held", 32'(word_cnt), 3);
    chk("t2_still_blocked", 32'(in_ready), 0);
    chk("t2_lo_empty", 32'(lo_valid), 0);
    chk("t2_hi_valid", 32'(hi_valid), 1);
    in_valid = 1'b0; hi_ready = 1'b1;
    step();
    step();
    chk("t2_hi_drained", 32'(hi_valid), 0);
    step();
    chk("t2_pop_empty_ignored", 32'(hi_valid), 0);
    chk("t2_pop_empty_cnt", 32'(word_cnt), 3);

    // Fill both to FULL, then push+pop in one cycle
    hi_ready = 1'b0; lo_ready = 1'b0;
    in_valid = 1'b1; in_data = DW'(5'b10111);
    step();
    in_data = DW'(5'b01001);
    step();
    in_valid = 1'b0;
    chk("t3_full_block", 32'(in_ready), 0);
    chk("t3_full_hi_head", 32'(hi_data), 3'b101);
    chk("t3_full_lo_head", 32'(lo_data), 2'b11);
    chk("t3_full_cnt", 32'(word_cnt), 5);
    hi_ready = 1'b1; lo_ready = 1'b1; in_valid = 1'b1; in_data = DW'(5'b11110);
    #1;
    chk("t3_passthru_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t3_pp_hi_head", 32'(hi_data), 3'b010);
    chk("t3_pp_lo_head", 32'(lo_data), 2'b01);
    chk("t3_pp_cnt", 32'(word_cnt), 6);
    step();
    chk("t3_order_hi", 32'(hi_data), 3'b111);
    chk("t3_order_lo", 32'(lo_data), 2'b10);
    chk("t3_order_valid", 32'(hi_valid & lo_valid), 1);
    step();
    chk("t3_drained", 32'(hi_valid | lo_valid), 0);

    // Stream 256 words through; counter wraps back to its start value
    exp_cnt = 8'd6;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 5'(i * 7 + 3);
      in_data = DW'(w);
      step();
      exp_cnt = exp_cnt + 8'd1;
      chk("t4_hi", 32'(hi_data), 32'(w[4:2]));
      chk("t4_lo", 32'(lo_data), 32'(w[1:0]));
      chk("t4_cnt", 32'(word_cnt), 32'(exp_cnt));
      if (exp_cnt == 8'd0) chk("t4_wrap_zero", 32'(word_cnt), 0);
    end
    in_valid = 1'b0;
    step();
    chk("t4_end_cnt", 32'(word_cnt), 6);
    chk("t4_end_drained", 32'(hi_valid | lo_valid), 0);

    // Async reset with both FIFOs full
    hi_ready = 1'b0; lo_ready = 1'b0; in_valid = 1'b1;
    in_data = DW'(5'h1F);
    step();
    in_data = DW'(5'h0A);
    step();
    in_valid = 1'b0;
    chk("t5_full", 32'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_hi_valid", 32'(hi_valid), 0);
    chk("t5_async_lo_valid", 32'(lo_valid), 0);
    chk("t5_async_cnt", 32'(word_cnt), 0);
    chk("t5_async_hi_data", 32'(hi_data), 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("t5_release_ready", 32'(in_ready), 1);
    chk("t5_release_valid", 32'(hi_valid | lo_valid), 0);

`ifdef CONCAT_SPLITTER_PARITY_EN
    // Bad-parity word still delivered, par_err pulses once
    hi_ready = 1'b1; lo_ready = 1'b1;
    in_valid = 1'b1; in_data = 6'b0_00001;
    step();
    in_valid = 1'b0;
    chk("par_err_pulse", 32'(par_err), 1);
    chk("par_hi_data", 32'(hi_data), 3'b000);
    chk("par_lo_data", 32'(lo_data), 2'b01);
    chk("par_cnt", 32'(word_cnt), 1);
    step();
    chk("par_err_clear", 32'(par_err), 0);
    in_valid = 1'b1; in_data = 6'b1_00001;
    step();
    in_valid = 1'b0;
    chk("par_good_word", 32'(par_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
